// File: rtl/char_match_seq.sv
// char_match_seq: run-time loadable template-matching character classifier.
// One template is scored per pixelclk against a latched character; the best
// index, its score and the best-to-second margin are returned through a
// valid/ready handshake.
// Optional feature macro: CHAR_MATCH_REJECT_EN (adds reject_thr / out_reject).
module char_match_seq #(
   parameter  int CHAR_W   = 40,
   parameter  int NUM_TMPL = 34,
   localparam int SW       = $clog2(CHAR_W + 1),
   localparam int IW       = $clog2(NUM_TMPL)
) (
   input  logic              pixelclk,
   input  logic              reset_n,
   input  logic              tmpl_we,
   input  logic [IW-1:0]     tmpl_addr,
   input  logic [CHAR_W-1:0] tmpl_data,
   input  logic [7:0]        tmpl_code,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CHAR_W-1:0] in_char,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [7:0]        out_code,
   output logic [IW-1:0]     out_idx,
   output logic [SW-1:0]     out_score,
   output logic [SW-1:0]     out_margin,
`ifdef CHAR_MATCH_REJECT_EN
   input  logic [SW-1:0]     reject_thr,
   output logic              out_reject,
`endif
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   state_t                          state_q, state_d;
   logic [NUM_TMPL-1:0][CHAR_W-1:0] tmpl_q, tmpl_d;
   logic [NUM_TMPL-1:0][7:0]        code_q, code_d;
   logic [CHAR_W-1:0]               char_q, char_d;
   logic [IW-1:0]                   idx_q, idx_d;
   logic [IW-1:0]                   bidx_q, bidx_d;
   logic [SW-1:0]                   best_q, best_d;
   logic [SW-1:0]                   second_q, second_d;
   logic                            out_valid_q, out_valid_d;
   logic [7:0]                      out_code_q, out_code_d;
   logic [IW-1:0]                   out_idx_q, out_idx_d;
   logic [SW-1:0]                   out_score_q, out_score_d;
   logic [SW-1:0]                   out_margin_q, out_margin_d;
`ifdef CHAR_MATCH_REJECT_EN
   logic                            out_reject_q, out_reject_d;
`endif

   // Running top-2 after folding in the current template's score.
   logic [SW-1:0] score;
   logic [SW-1:0] nb, ns;
   logic [IW-1:0] nbi;

   function automatic logic [SW-1:0] popcount(input logic [CHAR_W-1:0] v);
      logic [SW-1:0] c;
      c = '0;
      for (int i = 0; i < CHAR_W; i++) c = c + SW'(v[i]);
      return c;
   endfunction

   // Matching bits between the latched character and the template under scan.
   assign score = popcount(~(char_q ^ tmpl_q[idx_q]));

   // Top-2 tracking: strict > keeps the lowest index on ties, and an equal
   // later score lands in second so the margin collapses to zero.
   always_comb begin
      nb  = best_q;
      ns  = second_q;
      nbi = bidx_q;
      if (score > best_q) begin
         ns  = best_q;
         nb  = score;
         nbi = idx_q;
      end else if (score > second_q) begin
         ns  = score;
      end
   end

   // Next-state: template writes, FSM sequencing and result capture.
   always_comb begin
      state_d      = state_q;
      tmpl_d       = tmpl_q;
      code_d       = code_q;
      char_d       = char_q;
      idx_d        = idx_q;
      bidx_d       = bidx_q;
      best_d       = best_q;
      second_d     = second_q;
      out_valid_d  = out_valid_q;
      out_code_d   = out_code_q;
      out_idx_d    = out_idx_q;
      out_score_d  = out_score_q;
      out_margin_d = out_margin_q;
`ifdef CHAR_MATCH_REJECT_EN
      out_reject_d = out_reject_q;
`endif

      // Writes only land while idle so a scan always sees a stable table.
      if (state_q == S_IDLE && tmpl_we && (int'(tmpl_addr) < NUM_TMPL)) begin
         tmpl_d[tmpl_addr] = tmpl_data;
         code_d[tmpl_addr] = tmpl_code;
      end

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               char_d   = in_char;
               idx_d    = '0;
               best_d   = '0;
               second_d = '0;
               bidx_d   = '0;
               state_d  = S_SCAN;
            end
         end
         S_SCAN: begin
            best_d   = nb;
            second_d = ns;
            bidx_d   = nbi;
            idx_d    = idx_q + 1'b1;
            if (idx_q == IW'(NUM_TMPL - 1)) begin
               state_d      = S_DONE;
               out_valid_d  = 1'b1;
               out_idx_d    = nbi;
               out_score_d  = nb;
               out_margin_d = nb - ns;
               out_code_d   = code_q[nbi];
`ifdef CHAR_MATCH_REJECT_EN
               out_reject_d = (nb < reject_thr) || (nb == ns);
               if (out_reject_d) out_code_d = 8'h3F;
`endif
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and result registers; reset aborts any scan and clears the table.
   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         tmpl_q       <= '0;
         code_q       <= '0;
         char_q       <= '0;
         idx_q        <= '0;
         bidx_q       <= '0;
         best_q       <= '0;
         second_q     <= '0;
         out_valid_q  <= 1'b0;
         out_code_q   <= '0;
         out_idx_q    <= '0;
         out_score_q  <= '0;
         out_margin_q <= '0;
`ifdef CHAR_MATCH_REJECT_EN
         out_reject_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         tmpl_q       <= tmpl_d;
         code_q       <= code_d;
         char_q       <= char_d;
         idx_q        <= idx_d;
         bidx_q       <= bidx_d;
         best_q       <= best_d;
         second_q     <= second_d;
         out_valid_q  <= out_valid_d;
         out_code_q   <= out_code_d;
         out_idx_q    <= out_idx_d;
         out_score_q  <= out_score_d;
         out_margin_q <= out_margin_d;
`ifdef CHAR_MATCH_REJECT_EN
         out_reject_q <= out_reject_d;
`endif
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign out_valid  = out_valid_q;
   assign out_code   = out_code_q;
   assign out_idx    = out_idx_q;
   assign out_score  = out_score_q;
   assign out_margin = out_margin_q;
`ifdef CHAR_MATCH_REJECT_EN
   assign out_reject = out_reject_q;
`endif

endmodule

// File: tb/tb_char_match_seq.sv
// Self-checking bench for char_match_seq: directed cases plus random
// templates/characters against a top-2 reference model.
module tb_char_match_seq;
   localparam int CW = 40;
   localparam int NT = 34;
   localparam int SW = $clog2(CW + 1);
   localparam int IW = $clog2(NT);

   logic          pixelclk, reset_n;
   logic          tmpl_we;
   logic [IW-1:0] tmpl_addr;
   logic [CW-1:0] tmpl_data;
   logic [7:0]    tmpl_code;
   logic          in_valid, in_ready;
   logic [CW-1:0] in_char;
   logic          out_valid, out_ready;
   logic [7:0]    out_code;
   logic [IW-1:0] out_idx;
   logic [SW-1:0] out_score, out_margin;
   logic          busy;
`ifdef CHAR_MATCH_REJECT_EN
   logic [SW-1:0] reject_thr;
   logic          out_reject;
`endif

   char_match_seq #(.CHAR_W(CW), .NUM_TMPL(NT)) dut (
      .pixelclk(pixelclk), .reset_n(reset_n),
      .tmpl_we(tmpl_we), .tmpl_addr(tmpl_addr), .tmpl_data(tmpl_data), .tmpl_code(tmpl_code),
      .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_code(out_code), .out_idx(out_idx), .out_score(out_score), .out_margin(out_margin),
`ifdef CHAR_MATCH_REJECT_EN
      .reject_thr(reject_thr), .out_reject(out_reject),
`endif
      .busy(busy)
   );

   initial pixelclk = 1'b0;
   always #5 pixelclk = ~pixelclk;

   int n_asrt = 0;
   int n_fail = 0;

   // Reference template table.
   logic [CW-1:0] tm [NT];
   logic [7:0]    tc [NT];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge pixelclk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < NT; i++) begin
         tm[i] = '0;
         tc[i] = '0;
      end
   endtask

   task automatic load(input int a, input logic [CW-1:0] d, input logic [7:0] c);
      tmpl_we = 1'b1; tmpl_addr = IW'(a); tmpl_data = d; tmpl_code = c;
      step();
      tmpl_we = 1'b0;
      if (a < NT) begin
         tm[a] = d;
         tc[a] = c;
      end
   endtask

   // Expected result straight from the definition: first maximum wins,
   // second is the maximum over all other slots.
   task automatic model(input logic [CW-1:0] c, output int eb, output int es,
                        output int ei, output logic [7:0] ec);
      int s [NT];
      for (int i = 0; i < NT; i++) s[i] = $countones(~(c ^ tm[i]));
      eb = -1; ei = 0;
      for (int i = 0; i < NT; i++) if (s[i] > eb) begin eb = s[i]; ei = i; end
      es = -1;
      for (int i = 0; i < NT; i++) if (i != ei && s[i] > es) es = s[i];
      ec = tc[ei];
   endtask

   // Present one character, optionally writing at accept or mid-scan,
   // optionally backpressuring the result for bp cycles.
   task automatic run_char(input string tag, input logic [CW-1:0] c,
                           input bit wr_acc, input bit wr_scan, input int wa,
                           input logic [CW-1:0] wd, input logic [7:0] wc, input int bp);
      int eb, es, ei, n;
      logic [7:0] ec;
      logic [63:0] r;
      logic [7:0] h_code; logic [IW-1:0] h_idx; logic [SW-1:0] h_sc, h_mg;
      in_valid = 1'b1; in_char = c;
      if (wr_acc) begin
         tmpl_we = 1'b1; tmpl_addr = IW'(wa); tmpl_data = wd; tmpl_code = wc;
      end
      step();
      in_valid = 1'b0; tmpl_we = 1'b0;
      if (wr_acc && wa < NT) begin tm[wa] = wd; tc[wa] = wc; end
      model(c, eb, es, ei, ec);
      chk({tag, ".busy"}, 64'(busy), 64'(1));
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(0));
      n = 0;
      while (!out_valid && n < 200) begin
         if (wr_scan && n == 3) begin
            tmpl_we = 1'b1; tmpl_addr = IW'(wa); tmpl_data = wd; tmpl_code = wc;
         end else tmpl_we = 1'b0;
         step();
         n++;
      end
      tmpl_we = 1'b0;
      chk({tag, ".latency"}, 64'(n), 64'(NT));
      chk({tag, ".idx"}, 64'(out_idx), 64'(ei));
      chk({tag, ".score"}, 64'(out_score), 64'(eb));
      chk({tag, ".margin"}, 64'(out_margin), 64'(eb - es));
`ifdef CHAR_MATCH_REJECT_EN
      begin
         bit rj;
         rj = (eb < int'(reject_thr)) || (eb == es);
         chk({tag, ".reject"}, 64'(out_reject), 64'(rj));
         chk({tag, ".code"}, 64'(out_code), 64'(rj ? 8'h3F : ec));
      end
`else
      chk({tag, ".code"}, 64'(out_code), 64'(ec));
`endif
      h_code = out_code; h_idx = out_idx; h_sc = out_score; h_mg = out_margin;
      for (int k = 0; k < bp; k++) begin
         r = {$urandom, $urandom};
         in_valid = 1'b1; in_char = r[CW-1:0];
         step();
         chk({tag, ".bp_valid"}, 64'(out_valid), 64'(1));
         chk({tag, ".bp_in_ready"}, 64'(in_ready), 64'(0));
         chk({tag, ".bp_hold"}, {out_code, 8'(out_idx), 8'(out_score), 8'(out_margin)},
             {h_code, 8'(h_idx), 8'(h_sc), 8'(h_mg)});
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, ".post_valid"}, 64'(out_valid), 64'(0));
      chk({tag, ".post_in_ready"}, 64'(in_ready), 64'(1));
   endtask

   logic [63:0]   rv;
   logic [CW-1:0] ones, pat;

   initial begin
      ones = '1;
      pat  = 40'h0F0F0F0F0F;
      reset_n = 1'b0; tmpl_we = 1'b0; tmpl_addr = '0; tmpl_data = '0; tmpl_code = '0;
      in_valid = 1'b0; in_char = '0; out_ready = 1'b0;
`ifdef CHAR_MATCH_REJECT_EN
      reject_thr = '0;
`endif
      clear_model();
      repeat (3) step();
      reset_n = 1'b1;
      step();

      // Reset state
      chk("rst.out_valid", 64'(out_valid), 64'(0));
      chk("rst.outs", {out_code, 8'(out_idx), 8'(out_score), 8'(out_margin)}, 64'(0));
      chk("rst.busy", 64'(busy), 64'(0));
      chk("rst.in_ready", 64'(in_ready), 64'(1));
`ifdef CHAR_MATCH_REJECT_EN
      chk("rst.out_reject", 64'(out_reject), 64'(0));
`endif

      // Loaded identity and tie
      load(0, ones, 8'h30);
      run_char("ident", ones, 0, 0, 0, '0, '0, 0);
      chk("ident.score40", 64'(tm[0] == ones ? 40 : 0), 64'(40));
      run_char("tie", '0, 0, 0, 0, '0, '0, 0);

      // Backpressure, then an immediate follow-on accept
      rv = {$urandom, $urandom};
      run_char("bp", rv[CW-1:0], 0, 0, 0, '0, '0, 5);
      run_char("after_bp", pat, 0, 0, 0, '0, '0, 0);

      // Write lockout mid-scan, then the same write with the accept
      run_char("lock", pat, 0, 1, 5, pat, 8'h35, 0);
      run_char("lock_rb", pat, 0, 0, 0, '0, '0, 0);
      run_char("wr_acc", pat, 1, 0, 5, pat, 8'h35, 0);
      chk("wr_acc.idx5", 64'(out_idx), 64'(5));

      // Out-of-range write is dropped
      load(40, ones, 8'h77);
      run_char("oob", ones, 0, 0, 0, '0, '0, 0);

`ifdef CHAR_MATCH_REJECT_EN
      reject_thr = SW'(41);
      run_char("rej41", ones, 0, 0, 0, '0, '0, 0);
      chk("rej41.code", 64'(out_code), 64'(8'h3F));
      reject_thr = SW'(40);
      run_char("rej40", ones, 0, 0, 0, '0, '0, 0);
      chk("rej40.code", 64'(out_code), 64'(8'h30));
      reject_thr = '0;
`endif

      // Random tables and characters, some near-copies of a template
      for (int i = 0; i < NT; i++) begin
         rv = {$urandom, $urandom};
         load(i, rv[CW-1:0], 8'($urandom_range(8'h41, 8'h5A)));
      end
      for (int k = 0; k < 8; k++) begin
         rv = {$urandom, $urandom};
         if (k % 2 == 0) rv[CW-1:0] = tm[$urandom_range(0, NT - 1)] ^ (CW'(1) << $urandom_range(0, CW - 1));
         run_char("rand", rv[CW-1:0], 0, 0, 0, '0, '0, k % 3);
      end

      // Reset mid-scan
      in_valid = 1'b1; in_char = ones;
      step();
      in_valid = 1'b0;
      repeat (10) step();
      reset_n = 1'b0;
      #1;
      chk("mrst.out_valid", 64'(out_valid), 64'(0));
      chk("mrst.busy", 64'(busy), 64'(0));
      chk("mrst.in_ready", 64'(in_ready), 64'(1));
      repeat (2) step();
      reset_n = 1'b1;
      clear_model();
      repeat (NT + 4) step();
      chk("mrst.no_result", 64'(out_valid), 64'(0));
      run_char("cleared", ones, 0, 0, 0, '0, '0, 0);
      chk("cleared.score0", 64'(out_score), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #2000000;
      $display("FAIL watchdog: timeout reached, expected completion");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/char_match_seq.md
# char_match_seq

Parametrised, sequential template-matching character classifier for the plate-recognition pipeline. It sits after character segmentation/binarisation and replaces the fixed 40-bit, 34-template all-parallel matcher. Templates and their output codes are loaded at run time through a write port. One template is scored per pixelclk, and results are delivered through a valid/ready handshake with best index, score and best-to-second margin.

## Interface
- CHAR_W, default 40: bits per binarised character (1 = foreground).
- NUM_TMPL, default 34: template count, minimum 2.
- Derived: SW = $clog2(CHAR_W+1) score width; IW = $clog2(NUM_TMPL) index width.

Ports:
- pixelclk  in  1  clock; reset reset_n, asynchronous, active-low.
- reset_n  in  1  asynchronous active-low reset.
- tmpl_we  in  1  template write strobe; honoured only in IDLE.
- tmpl_addr  in  IW  template slot; writes with addr ≥ NUM_TMPL are dropped.
- tmpl_data  in  CHAR_W  template bit pattern.
- tmpl_code  in  8  ASCII result code for that slot.
- in_valid / in_ready  in / out  1  input handshake; in_ready = (state==IDLE).
- in_char  in  CHAR_W  character to classify.
- out_valid / out_ready  out / in  1  result handshake.
- out_code  out  8  code of the winning template.
- out_idx  out  IW  winning slot.
- out_score  out  SW  popcount(~(char ^ tmpl)) of the winner.
- out_margin  out  SW  best score minus second-best score.
- busy  out  1  state != IDLE.

## Operation
- Storage: NUM_TMPL × (CHAR_W + 8) register array, cleared to 0 by reset.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_char, set idx=0, best=0, second=0, bidx=0, then go to SCAN.
  - SCAN: each cycle, s = SCORE(char, tmpl[idx]).
    - If s > best: second←best, best←s, bidx←idx.
    - Else if s > second: second←s.
    - idx++.
    - After idx==NUM_TMPL-1, register the results and go to DONE.
  - DONE: out_valid=1; outputs are held stable. On out_ready, go to IDLE.
- Tie rule: strict > means the lowest index wins. An equal score from a later template sets second=best, so margin=0.
- Scores are saturation-free: the maximum is CHAR_W, which fits in SW bits. out_margin never underflows.
- Template writes:
  - Writes in IDLE take effect at the next edge.
  - tmpl_we in SCAN or DONE is ignored; no queuing.
  - A write and an in_valid accept in the same IDLE cycle both occur, and the scan sees the new template.

## Timing
- Acceptance edge T (in_valid & in_ready). Scans occur at edges T+1..T+NUM_TMPL. out_valid rises after edge T+NUM_TMPL.
- Latency is NUM_TMPL cycles; throughput is one character per NUM_TMPL+2 cycles with out_ready held high.
- out_valid & out_ready at edge U gives in_ready=1 after U. The next accept is possible at U+1; there is no combinational ready path from out to in.
- Reset values: out_valid=0, out_code=0, out_idx=0, out_score=0, out_margin=0, busy=0, in_ready=1 after release, FSM in IDLE, templates all 0.
- Reset asserted mid-SCAN or in DONE aborts immediately. No result is emitted and templates are cleared; software must reload.

## Configuration
- Macro CHAR_MATCH_REJECT_EN.
- Defined:
  - Adds input reject_thr [SW] and output out_reject [1] (reset 0).
  - At the DONE transition, if best < reject_thr or margin == 0: out_reject=1 and out_code=8'h3F ('?'). out_idx and out_score are still reported.
- Undefined: the ports are absent and out_code always equals tmpl_code[bidx].

## Test plan
- Loaded identity: after reset, load slot0 = 40'hFF_FFFF_FFFF with code 8'h30. Present char 40'hFF_FFFF_FFFF -> out_code=8'h30, out_idx=0, out_score=40, out_margin=40, out_valid exactly 34 cycles after accept.
- Tie: with only slot0 loaded as above, present char 40'h0 -> out_idx=1, out_score=40, out_margin=0, out_code=8'h00.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> all outputs stable, in_ready=0, in_valid ignored. Raise out_ready -> next char accepted one cycle later.
- Write lockout: during SCAN, write slot5 = 40'h0F0F0F0F0F -> slot contents unchanged on a later readback match. The same write in IDLE, together with in_valid, is used by that scan.
- Reset mid-scan: drop reset_n at scan cycle 10 -> out_valid stays 0, busy=0, and a subsequent all-ones char scores 0 against every cleared slot.
- CHAR_MATCH_REJECT_EN: run the loaded-identity case with reject_thr=41 -> out_reject=1, out_code=8'h3F, out_score=40. With reject_thr=40 -> out_reject=0, out_code=8'h30.
